fifo_read_serializer: RTL and testbench
=======================================

// Module: fifo_read_serializer
// PURPOSE
//  Read-side consumer of the multi-rate FIFO datapath. Pops one J-word group
//  from the buffer when data is available, then emits it one WIDTH-bit word per
//  cycle on a valid/ready stream. Its fifo_rd output drives the read-pointer
//  load (ld3) of the FIFO datapath.
// PARAMETERS
//  WIDTH  8              bits per word
//  J      4              words per FIFO read group (must match FIFO J, J>=1)
//  CNT_W  $clog2(J+1)    width of remaining-word counter
// PORTS
//  clk         in   1          single clock; all state updates on rising edge
//  rst         in   1          synchronous, active-high reset
//  fifo_data   in   WIDTH*J    FIFO par_out; word i = bits [i*WIDTH +: WIDTH]
//  fifo_empty  in   1          FIFO empty flag; high = fewer than J words held
//  fifo_rd     out  1          pop strobe; advances FIFO read pointer at next edge
//  dout        out  WIDTH      serial output word
//  dout_valid  out  1          dout holds a valid word
//  dout_ready  in   1          downstream accepts dout this cycle
//  busy        out  1          high while a group is held (state SEND)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, shift reg=0, cnt=0. Outputs after
//    reset: dout_valid=0, dout=0, busy=0, fifo_rd=0 (rst gates fifo_rd low).
//  - fifo_data is combinational from the FIFO read pointer; it is sampled in
//    the same cycle fifo_rd=1, and the pointer moves at that edge.
//  - States: IDLE (no group held), SEND (group held, cnt words remain).
//  - IDLE: fifo_rd = !fifo_empty. If fifo_rd: load shift reg <= fifo_data,
//    cnt <= J, go to SEND. Else stay in IDLE.
//  - SEND: dout = shift reg word 0 (lowest WIDTH bits); dout_valid=1; busy=1.
//    Transfer occurs when dout_valid && dout_ready.
//    * transfer, cnt>1: shift reg >>= WIDTH (zero fill), cnt <= cnt-1.
//    * transfer, cnt==1 (last word), fifo_empty=0: fifo_rd=1 in this cycle,
//      reload shift reg, cnt <= J, stay in SEND (no bubble between groups).
//    * transfer, cnt==1, fifo_empty=1: go to IDLE, dout_valid drops next cycle.
//    * no transfer: shift reg, cnt, dout held stable (AXI-style: valid never
//      withdrawn, data never changes while stalled).
//  - fifo_rd is never high when fifo_empty=1, and never high in SEND except
//    on the last-word transfer cycle. At most one pop per cycle.
//  - Latency: fifo_empty falls in cycle t (IDLE) -> fifo_rd in t ->
//    first word valid in t+1. Throughput with dout_ready=1: 1 word/cycle.
//  - Word order: word 0 first, word J-1 last.
//  - J=1: every transfer is a last-word transfer.
//  - rst mid-group: remaining words discarded, no pop issued in reset cycle;
//    FIFO pointers are reset by the same rst.
//  - dout_ready ignored in IDLE. X on fifo_data is tolerated when fifo_rd=0.
// TESTING
//  1. Hold rst 2 cycles with fifo_empty=0 -> fifo_rd=0, dout_valid=0, busy=0.
//  2. fifo_data=32'h44332211, fifo_empty low 1 cycle, dout_ready=1 -> one
//     fifo_rd pulse; dout 8'h11,8'h22,8'h33,8'h44 on 4 consecutive cycles;
//     then dout_valid=0.
//  3. Same group, dout_ready=0 for 3 cycles after first beat -> dout stays
//     8'h22 with dout_valid=1 throughout stall; no extra fifo_rd.
//  4. Two groups 32'h44332211, 32'h88776655 available, ready=1 -> 8
//     back-to-back beats 11..88, second fifo_rd coincides with beat 8'h44.
//  5. rst asserted after beats 11,22 -> next cycle dout_valid=0, busy=0; with
//     fifo_empty=1 after reset no beats ever appear.
//  6. fifo_empty=1 for 20 cycles, ready=1 -> fifo_rd and dout_valid never 1.

Source files
------------

// File: rtl/fifo_read_serializer.sv
// Purpose : pops one J-word group from the FIFO and streams it out one word per cycle.
// Latency : fifo_rd in the cycle fifo_empty falls (IDLE), first word valid the next cycle.
// Backpr. : valid/ready; a stalled word is held stable, and the FIFO is not popped until the last word leaves.
//
// Ports
//   i_clk         single clock, all state on the rising edge
//   i_rst         synchronous active-high reset
//   i_fifo_data   FIFO par_out, word i = bits [i*WIDTH +: WIDTH]
//   i_fifo_empty  high while the FIFO holds fewer than J words
//   o_fifo_rd     pop strobe; the FIFO read pointer advances at the next edge
//   o_dout        serial output word (word 0 of the held group first)
//   o_dout_valid  o_dout carries a word
//   i_dout_ready  downstream accepts o_dout this cycle
//   o_busy        a group is held (SEND state)
module fifo_read_serializer #(
  parameter int WIDTH = 8,
  parameter int J     = 4,
  parameter int CNT_W = $clog2(J + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [WIDTH*J-1:0] i_fifo_data,
  input  logic               i_fifo_empty,
  output logic               o_fifo_rd,
  output logic [WIDTH-1:0]   o_dout,
  output logic               o_dout_valid,
  input  logic               i_dout_ready,
  output logic               o_busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(J);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t               r_state;
  logic [WIDTH*J-1:0]   r_shift;   // held group, current word in the low WIDTH bits
  logic [CNT_W-1:0]     r_cnt;     // words of the held group not yet transferred
  logic                 r_valid;   // registered copy of (r_state == ST_SEND)
  logic                 r_busy;

  logic                 w_xfer;
  logic                 w_last;
  logic                 w_fifo_rd;

  // r_valid is only ever set together with ST_SEND, so it doubles as the
  // "in SEND" qualifier and keeps ready out of the IDLE path entirely.
  assign w_xfer = r_valid & i_dout_ready;
  assign w_last = (r_cnt == CNT_ONE);

  // The pop is combinational: the FIFO presents its group on i_fifo_data in
  // the same cycle, and we capture it at the edge that moves the pointer.
  // In SEND a pop only happens on the last-word transfer so the next group
  // follows without a bubble. Reset forces the strobe low so the FIFO does
  // not advance while both sides are being cleared.
  assign w_fifo_rd = ~i_rst & ~i_fifo_empty &
                     ((r_state == ST_IDLE) | (w_xfer & w_last));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fifo_rd) begin
            r_shift <= i_fifo_data;
            r_cnt   <= CNT_FULL;
            r_state <= ST_SEND;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        ST_SEND: begin
          // Without a transfer nothing moves: word and valid stay put.
          if (w_xfer) begin
            if (!w_last) begin
              r_shift <= r_shift >> WIDTH;
              r_cnt   <= r_cnt - CNT_ONE;
            end else if (w_fifo_rd) begin
              // Back-to-back group: reload in place and stay in SEND.
              r_shift <= i_fifo_data;
              r_cnt   <= CNT_FULL;
            end else begin
              // Only the last word was left, so this shift leaves the
              // register all zero and o_dout idles at 0.
              r_shift <= r_shift >> WIDTH;
              r_cnt   <= '0;
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_fifo_rd    = w_fifo_rd;
  assign o_dout       = r_shift[WIDTH-1:0];
  assign o_dout_valid = r_valid;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_fifo_read_serializer.sv
module tb_fifo_read_serializer;
  localparam int WIDTH = 8;
  localparam int J     = 4;
  localparam int GW    = WIDTH * J;

  logic             clk = 1'b0;
  logic             rst;
  logic [GW-1:0]    fifo_data;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;

  always #5 clk = ~clk;

  fifo_read_serializer #(.WIDTH(WIDTH), .J(J)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (fifo_empty),
    .o_fifo_rd    (fifo_rd),
    .o_dout       (dout),
    .o_dout_valid (dout_valid),
    .i_dout_ready (dout_ready),
    .o_busy       (busy)
  );

  // Reference model: a queue of whole groups sitting in the FIFO, the flat
  // stream of words the consumer must emit in order, and how many words of
  // already-popped groups are still owed downstream.
  logic [GW-1:0]    fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  int               held;
  int               n_assert;
  int               n_fail;
  int               n_rd;
  logic [WIDTH-1:0] rd_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_group(input logic [GW-1:0] g);
    fifo_q.push_back(g);
    for (int i = 0; i < J; i++) exp_q.push_back(g[i*WIDTH +: WIDTH]);
    drive_fifo();
  endtask

  // One clock cycle: compare at the falling edge, advance the model after
  // the rising edge, then present the FIFO's new head.
  task automatic tick();
    bit beat;
    bit exp_rd;
    @(negedge clk);
    beat   = !rst && (held > 0) && dout_ready;
    exp_rd = !rst && !fifo_empty && ((held == 0) || (held == 1 && beat));
    check("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
    check("dout_valid", 32'(dout_valid), 32'(held > 0));
    check("busy", 32'(busy), 32'(held > 0));
    if (held > 0 && exp_q.size() != 0) check("dout", 32'(dout), 32'(exp_q[0]));
    if (fifo_rd) begin
      n_rd++;
      if (held > 0) rd_dout = dout;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      fifo_q.delete();
      exp_q.delete();
      held = 0;
    end else begin
      if (exp_rd && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        held += J;
      end
      if (beat) begin
        void'(exp_q.pop_front());
        held--;
      end
    end
    drive_fifo();
  endtask

  initial begin
    n_assert = 0; n_fail = 0; n_rd = 0; held = 0; rd_dout = '0;
    rst = 1'b1; dout_ready = 1'b0;
    fifo_q.delete(); exp_q.delete();
    drive_fifo();
    @(posedge clk);
    #1;

    // 1: reset held with data available -> no pop, outputs idle
    push_group(32'hdeadbeef);
    dout_ready = 1'b1;
    repeat (2) tick();
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    rst = 1'b0;

    // 2: single group, ready throughout
    n_rd = 0;
    push_group(32'h44332211);
    dout_ready = 1'b1;
    repeat (6) tick();
    check("t2_rd_count", n_rd, 32'd1);
    check("t2_idle_valid", 32'(dout_valid), 32'd0);

    // 3: stall for 3 cycles after the first beat
    n_rd = 0;
    push_group(32'h44332211);
    tick();
    tick();
    dout_ready = 1'b0;
    repeat (3) tick();
    check("t3_stall_dout", 32'(dout), 32'h22);
    check("t3_stall_valid", 32'(dout_valid), 32'd1);
    dout_ready = 1'b1;
    repeat (4) tick();
    check("t3_rd_count", n_rd, 32'd1);
    check("t3_idle_valid", 32'(dout_valid), 32'd0);

    // 4: two groups back to back, second pop on beat 8'h44
    n_rd = 0;
    rd_dout = '0;
    push_group(32'h44332211);
    push_group(32'h88776655);
    repeat (10) tick();
    check("t4_rd_count", n_rd, 32'd2);
    check("t4_rd_on_beat", 32'(rd_dout), 32'h44);

    // 5: reset after two beats discards the rest
    push_group(32'h44332211);
    repeat (3) tick();
    check("t5_mid_dout", 32'(dout), 32'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid", 32'(dout_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    n_rd = 0;
    repeat (10) tick();
    check("t5_rd_count", n_rd, 32'd0);

    // 6: long empty period
    n_rd = 0;
    repeat (20) tick();
    check("t6_rd_count", n_rd, 32'd0);

    // 7: random arrivals, random backpressure, rare resets
    for (int c = 0; c < 800; c++) begin
      if (fifo_q.size() < 3 && $urandom_range(0, 2) == 0) push_group(GW'($urandom));
      dout_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    dout_ready = 1'b1;
    repeat (60) tick();
    check("t7_drained_valid", 32'(dout_valid), 32'd0);
    check("t7_drained_empty", 32'(fifo_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
